uart_cfg: RTL and testbench
===========================

# uart_cfg

Parametrised successor to the team's fixed 8N1 UART, on the same 16-bit register I/O bus. It adds:
- a configurable data width, FIFO depth and oversampling ratio;
- run-time parity and stop-bit selection;
- parity, framing and break detection, plus a sticky overflow flag;
- break transmission, FIFO flush and a selectable half-duplex receive gate.

It drives a line transceiver through txd/txen.

## Interface
- DBITS, 8, data bits per frame, legal range 5..9
- AW, 5, log2 of FIFO depth; both RX and TX FIFOs hold 2^AW words
- OVS, 16, bus-clock enable ticks per bit (oversampling ratio); even, range 8..64

Ports:
- clk  in  1  master clock
- rst  in  1  reset; one clock, synchronous, active-high
- iocs  in  1  module select
- ioaddr  in  3  register address; bits [1:0] decoded, bit 2 ignored
- din  in  16  write data
- iowr  in  1  write strobe, qualified by iocs
- iord  in  1  read strobe, qualified by iocs
- dout  out  16  registered read data
- rxd  in  1  serial input, asynchronous
- txd  out  1  serial output, registered, idle high
- txen  out  1  transmitter active / driver enable

## Operation
Write registers:
- **W0:** din[DBITS-1:0] is pushed to the TX FIFO. The write is ignored if the FIFO is full, unless a pop occurs in the same cycle.
- **W1:** baud divisor, 16 bits. The tick counter resets to 0 on this write, and the new value takes effect immediately.
- **W2:** control register.
  - [1:0] parity: 00 none, 01 even, 10 odd, 11 mark (parity bit = 1).
  - [2] two stop bits.
  - [3] half-duplex: rxd is forced high while txen is set.
  - [4] break.
  - [5] RX flush, write-one, self-clearing.
  - [6] TX flush, write-one, self-clearing.

Read registers:
- **R0:** pops the RX FIFO.
  - dout[DBITS-1:0] = data; [12] BRK, [13] PE, [14] FE; other bits 0.
  - A read of R0 while the FIFO is empty leaves the pointers unchanged and returns the stale head value.
- **R1:** status.
  - [0] RXR (RX FIFO not empty), [1] RXF (RX FIFO full), [2] TXR (TX FIFO not full), [3] TXE (TX FIFO empty), [4] OVR (sticky), [5] txen.
  - A read of R1 clears OVR.
- **R2:** control readback; bits [4:0] only.
- **R3:** reads as 0.

Tick generator:
- en pulses for one clock every baud+1 clocks.
- baud = 0 gives en on every clock.

Receiver:
- rxd passes through 2 synchroniser FFs.
- FSM states: IDLE, START, DATA, PAR, STOP, WAITHI.
  - IDLE→START on a high-to-low transition seen at an en tick.
  - START: OVS/2 ticks later the line is sampled. If it is high, the start is false → IDLE. If it is low, → DATA.
  - DATA: bits are sampled every OVS ticks, LSB first.
  - PAR: entered only when parity is enabled.
  - STOP: samples the first stop bit only, then the word is pushed.
- Frame status bits:
  - FE = stop bit sampled 0.
  - PE = parity mismatch.
  - BRK = all data bits, the parity bit (if enabled) and the stop bit are 0.
- On BRK, the FSM goes to WAITHI and returns to IDLE only after a high sample.
- Push when the RX FIFO is full: the word is dropped and OVR is set.
- Parity mode is latched at the start of each frame.

Transmitter:
- FSM states: IDLE, START, DATA, PAR, STOP1, STOP2. Each bit lasts OVS ticks.
- IDLE: at an en tick with the TX FIFO non-empty and break clear, pop a word and enter START.
- Parity and stop-bit configuration is latched at the pop.
- After the final stop bit, if the FIFO is non-empty, the next START begins on the next tick, with no gap.
- Break: txd is forced low and txen is held high. A frame in progress completes on the shifter, but no new frame starts until break clears.
- Flush: empties the respective FIFO. RX flush also clears OVR. A frame in progress completes.

## Timing
- **Reset values:**
  - txd=1, txen=0, dout=0, baud=0, control=0 (8N1, full duplex).
  - Both FIFOs empty, OVR=0, both FSMs IDLE.
- **Read path:** dout is updated on the clock edge after iord. Status reflects the cycle in which iord is sampled. An RX pop on R0 takes effect on that same edge.
- **Transmit path:**
  - txd is registered; it changes 1 clk after the en tick.
  - txen rises with the START bit's txd edge. It falls 1 clk after the STOP1 or STOP2 tick-end when the FIFO is empty.
  - Frame length = (1 + DBITS + parity? + stops) × OVS ticks.
- **Receive path:**
  - The word is pushed at the centre of the stop bit: (1 + DBITS + parity?) × OVS + OVS/2 ticks after the start edge.
  - RXR is visible 1 clk after the push.
- **Mid-operation events:**
  - A rst mid-frame aborts both FSMs immediately.
  - A simultaneous push and pop on a full FIFO is accepted.

## Test plan
1. **8N1 loopback:** baud=3, rxd tied to txd, W0=0xA5. Required:
   - txen is high for exactly 10×16×4 = 640 clks.
   - R0 returns 0x0A5, with no PE/FE/BRK.
2. **7E2 parity and framing errors:** DBITS=7, ctrl=0x05. Inject 0x41 with a wrong parity bit → PE=1. Inject with the stop bit low → FE=1.
3. **Break:**
   - Hold rxd low for 2 frame times. Required: exactly one word with BRK=1, FE=1, data 0; no second word until rxd goes high.
   - Set ctrl[4]. Required: txd=0 and txen=1.
4. **Overflow:** send 33 frames without reading. Required:
   - RXF=1 and OVR=1; 32 words are readable in order.
   - A subsequent R1 read returns OVR=0.
5. **False start and half-duplex:**
   - A 0.25-bit low glitch on rxd → no word is pushed.
   - With ctrl[3] set, rxd looped back to txd during a 3-byte TX burst → RX FIFO stays empty.
6. **Back-to-back TX:** write 3 words. Required:
   - txen stays continuously high.
   - Each start bit immediately follows the previous stop bit.
   - TXE rises at the third pop.

Source files
------------

// File: rtl/uart_cfg_if.sv
// uart_cfg_if: 16-bit register I/O bus shared by the host and the UART
interface uart_cfg_if;
   logic iocs;
   logic iowr;
   logic iord;
   logic [2:0] ioaddr;
   logic [15:0] din;
   logic [15:0] dout;
   modport master (output iocs, iowr, iord, ioaddr, din, input dout);
   modport slave (input iocs, iowr, iord, ioaddr, din, output dout);
endinterface

// File: rtl/uart_cfg.sv
// uart_cfg: parametrised UART on the 16-bit register bus with FIFOs, parity, break and overflow detection
module uart_cfg #(
   parameter int DBITS = 8,
   parameter int AW = 5,
   parameter int OVS = 16
) (
   input logic clk,
   input logic rst,
   uart_cfg_if.slave bus,
   input logic rxd,
   output logic txd,
   output logic txen
);
   localparam int CW = $clog2(OVS);
   localparam int BW = $clog2(DBITS);
   localparam int N = 1 << AW;
   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAITHI} rstate_t;
   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP1, T_STOP2} tstate_t;
   rstate_t rs, rs_n;
   tstate_t ts, ts_n;
   logic wr, rd, en, ovr, rx_prev, r1, r2, rxs, unused;
   logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop, rx_wr, rx_flush, tx_flush;
   logic r_smp, r_pe, r_brk, rpb, t_end, t_go, tpb, tpen, tstop2, txd_n;
   logic [1:0] a, rpar;
   logic [4:0] ctrl;
   logic [15:0] baud, cnt;
   logic [CW-1:0] rcnt, tcnt;
   logic [BW-1:0] rbit, tbit;
   logic [DBITS-1:0] rsh, tsh, tsh_n, tx_head;
   logic [DBITS+2:0] rx_head;
   logic [DBITS-1:0] tx_mem [N];
   logic [DBITS+2:0] rx_mem [N];
   logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
   assign unused = ^{bus.ioaddr[2], bus.din};
   assign wr = bus.iocs & bus.iowr;
   assign rd = bus.iocs & bus.iord;
   assign a = bus.ioaddr[1:0];
   assign en = cnt == baud;
   assign rx_flush = wr && a == 2'd2 && bus.din[5];
   assign tx_flush = wr && a == 2'd2 && bus.din[6];
   assign tx_empty = tx_wp == tx_rp;
   assign rx_empty = rx_wp == rx_rp;
   assign tx_full = tx_wp == (tx_rp ^ (AW+1)'(N));
   assign rx_full = rx_wp == (rx_rp ^ (AW+1)'(N));
   assign tx_push = wr && a == 2'd0 && (!tx_full || tx_pop);
   assign rx_pop = rd && a == 2'd0 && !rx_empty;
   assign rx_wr = rx_push && (!rx_full || rx_pop);
   assign tx_head = tx_mem[tx_rp[AW-1:0]];
   assign rx_head = rx_mem[rx_rp[AW-1:0]];
   // half-duplex gate hides our own transmission from the receiver
   assign rxs = r2 | (ctrl[3] & txen);
   assign r_smp = en && rcnt == (rs == R_START ? CW'(OVS/2-1) : CW'(OVS-1));
   assign r_pe = rpar == 2'b01 ? rpb != ^rsh : rpar == 2'b10 ? rpb == ^rsh : rpar == 2'b11 ? !rpb : 1'b0;
   assign r_brk = rsh == '0 && !rpb && !rxs;
   assign t_end = en && tcnt == CW'(OVS-1);
   assign t_go = en && !tx_empty && !ctrl[4];
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.din[DBITS-1:0];
      if (rx_wr) rx_mem[rx_wp[AW-1:0]] <= {!rxs, r_pe, r_brk, rsh};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         baud <= '0;
         cnt <= '0;
         ctrl <= '0;
         ovr <= 1'b0;
         r1 <= 1'b1;
         r2 <= 1'b1;
         rx_prev <= 1'b1;
         tx_wp <= '0;
         tx_rp <= '0;
         rx_wp <= '0;
         rx_rp <= '0;
         bus.dout <= '0;
      end else begin
         cnt <= (wr && a == 2'd1) || en ? '0 : cnt + 16'd1;
         if (wr && a == 2'd1) baud <= bus.din;
         if (wr && a == 2'd2) ctrl <= bus.din[4:0];
         r1 <= rxd;
         r2 <= r1;
         if (en) rx_prev <= rxs;
         tx_wp <= tx_flush ? '0 : tx_wp + (AW+1)'(tx_push);
         tx_rp <= tx_flush ? '0 : tx_rp + (AW+1)'(tx_pop);
         rx_wp <= rx_flush ? '0 : rx_wp + (AW+1)'(rx_wr);
         rx_rp <= rx_flush ? '0 : rx_rp + (AW+1)'(rx_pop);
         ovr <= (rx_push && !rx_wr) || (ovr && !rx_flush && !(rd && a == 2'd1));
         if (rd) bus.dout <= a == 2'd0 ? {1'b0, rx_head[DBITS+2:DBITS], 12'(rx_head[DBITS-1:0])}
            : a == 2'd1 ? {10'd0, txen, ovr, tx_empty, !tx_full, rx_full, !rx_empty}
            : a == 2'd2 ? {11'd0, ctrl} : 16'd0;
      end
   end
   always_comb begin
      rs_n = rs;
      rx_push = 1'b0;
      case (rs)
         R_IDLE: if (en && rx_prev && !rxs) rs_n = R_START;
         R_START: if (r_smp) rs_n = rxs ? R_IDLE : R_DATA;
         R_DATA: if (r_smp && rbit == BW'(DBITS-1)) rs_n = rpar != 2'b00 ? R_PAR : R_STOP;
         R_PAR: if (r_smp) rs_n = R_STOP;
         R_STOP: if (r_smp) begin
            rx_push = 1'b1;
            rs_n = r_brk ? R_WAITHI : R_IDLE;
         end
         R_WAITHI: if (en && rxs) rs_n = R_IDLE;
         default: rs_n = R_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rs <= R_IDLE;
         rcnt <= '0;
         rbit <= '0;
         rsh <= '0;
         rpar <= 2'b00;
         rpb <= 1'b0;
      end else begin
         rs <= rs_n;
         rcnt <= r_smp || rs_n != rs ? '0 : rcnt + CW'(en);
         if (rs == R_IDLE) begin
            rpar <= ctrl[1:0];
            rbit <= '0;
            rpb <= 1'b0;
         end
         if (r_smp && rs == R_DATA) begin
            rsh <= {rxs, rsh[DBITS-1:1]};
            rbit <= rbit + BW'(1);
         end
         if (r_smp && rs == R_PAR) rpb <= rxs;
      end
   end
   always_comb begin
      ts_n = ts;
      tx_pop = 1'b0;
      case (ts)
         T_IDLE: if (t_go) begin
            tx_pop = 1'b1;
            ts_n = T_START;
         end
         T_START: if (t_end) ts_n = T_DATA;
         T_DATA: if (t_end && tbit == BW'(DBITS-1)) ts_n = tpen ? T_PAR : T_STOP1;
         T_PAR: if (t_end) ts_n = T_STOP1;
         T_STOP1, T_STOP2: if (t_end) begin
            if (ts == T_STOP1 && tstop2) ts_n = T_STOP2;
            else if (t_go) begin
               tx_pop = 1'b1;
               ts_n = T_START;
            end else ts_n = T_IDLE;
         end
         default: ts_n = T_IDLE;
      endcase
      tsh_n = tx_pop ? tx_head : (ts == T_DATA && t_end) ? tsh >> 1 : tsh;
      txd_n = ctrl[4] ? 1'b0 : ts_n == T_START ? 1'b0 : ts_n == T_DATA ? tsh_n[0] : ts_n == T_PAR ? tpb : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         ts <= T_IDLE;
         tcnt <= '0;
         tbit <= '0;
         tsh <= '0;
         tpb <= 1'b0;
         tpen <= 1'b0;
         tstop2 <= 1'b0;
         txd <= 1'b1;
         txen <= 1'b0;
      end else begin
         ts <= ts_n;
         tcnt <= t_end || ts_n != ts ? '0 : tcnt + CW'(en);
         tsh <= tsh_n;
         if (tx_pop) tbit <= '0;
         else if (ts == T_DATA && t_end) tbit <= tbit + BW'(1);
         if (tx_pop) begin
            tpen <= ctrl[1:0] != 2'b00;
            tstop2 <= ctrl[2];
            tpb <= ctrl[1:0] == 2'b11 || (ctrl[1:0] == 2'b01 && ^tx_head) || (ctrl[1:0] == 2'b10 && ~^tx_head);
         end
         txd <= txd_n;
         txen <= ctrl[4] | (ts_n != T_IDLE);
      end
   end
endmodule

// File: tb/tb_uart_cfg.sv
// tb_uart_cfg: scoreboard bench for uart_cfg; reads queue their expected value, a monitor compares dout
module tb_uart_cfg;
   logic clk = 1'b0, rst = 1'b1, loop = 1'b0, rx_drv8 = 1'b1, rx_drv7 = 1'b1;
   logic rdq8 = 1'b0, rdq7 = 1'b0;
   logic rxd8, txd8, txen8, txd7, txen7, to;
   logic [63:0] bits;
   int len;
   int checks = 0, failures = 0;
   logic [15:0] exp_q[$];
   string name_q[$];
   uart_cfg_if bus8();
   uart_cfg_if bus7();
   assign rxd8 = loop ? txd8 : rx_drv8;
   uart_cfg u8 (.clk(clk), .rst(rst), .bus(bus8), .rxd(rxd8), .txd(txd8), .txen(txen8));
   uart_cfg #(.DBITS(7)) u7 (.clk(clk), .rst(rst), .bus(bus7), .rxd(rx_drv7), .txd(txd7), .txen(txen7));
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
      checks++;
      if (act !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, act, e);
      end
   endtask
   always @(posedge clk) begin
      rdq8 <= bus8.iocs & bus8.iord;
      rdq7 <= bus7.iocs & bus7.iord;
   end
   always @(negedge clk) begin
      if (rdq8 || rdq7) begin
         if (exp_q.size() == 0) chk("unexpected_read", 32'(rdq8 ? bus8.dout : bus7.dout), 32'hFFFF_FFFF);
         else chk(name_q.pop_front(), 32'(rdq8 ? bus8.dout : bus7.dout), 32'(exp_q.pop_front()));
      end
   end
   task automatic strobe(input bit s7, input bit w, input logic [2:0] ad, input logic [15:0] d);
      @(posedge clk);
      #1;
      if (s7) begin
         bus7.iocs = 1'b1; bus7.iowr = w; bus7.iord = !w; bus7.ioaddr = ad; bus7.din = d;
      end else begin
         bus8.iocs = 1'b1; bus8.iowr = w; bus8.iord = !w; bus8.ioaddr = ad; bus8.din = d;
      end
      @(posedge clk);
      #1;
      bus8.iocs = 1'b0; bus8.iowr = 1'b0; bus8.iord = 1'b0;
      bus7.iocs = 1'b0; bus7.iowr = 1'b0; bus7.iord = 1'b0;
   endtask
   task automatic wr(input bit s7, input logic [2:0] ad, input logic [15:0] d);
      strobe(s7, 1'b1, ad, d);
   endtask
   task automatic rd(input bit s7, input logic [2:0] ad, input logic [15:0] e, input string n);
      exp_q.push_back(e);
      name_q.push_back(n);
      strobe(s7, 1'b0, ad, 16'h0000);
   endtask
   // serial frames at baud=0: 16 clocks per bit, LSB first
   task automatic send8(input logic [7:0] d);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx_drv8 = f[i];
         repeat (16) @(posedge clk);
      end
      rx_drv8 = 1'b1;
   endtask
   task automatic send7(input logic [6:0] d, input logic p, input logic s);
      logic [10:0] f;
      f = {1'b1, s, p, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_drv7 = f[i];
         repeat (16) @(posedge clk);
      end
      rx_drv7 = 1'b1;
   endtask
   // length of the next txen pulse, sampling txd at each bit centre (64 clocks per bit at baud=3)
   task automatic meas(output int l, output logic [63:0] b, output logic t);
      l = 0;
      b = '0;
      t = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 400 && !txen8; i++) @(negedge clk);
      if (!txen8) t = 1'b1;
      while (txen8 && l < 4000) begin
         if (l % 64 == 32) b[l/64] = txd8;
         l++;
         @(negedge clk);
      end
      if (l >= 4000) t = 1'b1;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end
   initial begin
      bus8.iocs = 1'b0; bus8.iowr = 1'b0; bus8.iord = 1'b0; bus8.ioaddr = '0; bus8.din = '0;
      bus7.iocs = 1'b0; bus7.iowr = 1'b0; bus7.iord = 1'b0; bus7.ioaddr = '0; bus7.din = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_txd", 32'(txd8), 32'd1);
      chk("rst_txen", 32'(txen8), 32'd0);
      chk("rst_dout", 32'(bus8.dout), 32'd0);
      chk("rst_txd7", 32'(txd7), 32'd1);
      chk("rst_txen7", 32'(txen7), 32'd0);
      rd(0, 3'd1, 16'h000C, "rst_status");
      rd(0, 3'd2, 16'h0000, "rst_ctrl");
      rd(0, 3'd3, 16'h0000, "r3_zero");
      loop = 1'b1;
      wr(0, 3'd1, 16'd3);
      wr(0, 3'd0, 16'h00A5);
      meas(len, bits, to);
      chk("t1_timeout", 32'(to), 32'd0);
      chk("t1_txen_len", 32'(len), 32'd640);
      chk("t1_txd_bits", 32'(bits[9:0]), 32'h34A);
      repeat (20) @(posedge clk);
      rd(0, 3'd0, 16'h00A5, "t1_rx_word");
      rd(0, 3'b101, 16'h000C, "t1_status_a2");
      loop = 1'b0;
      fork
         meas(len, bits, to);
         begin
            wr(0, 3'd0, 16'h0011);
            wr(0, 3'd0, 16'h0022);
            wr(0, 3'd0, 16'h0033);
            for (int i = 0; i < 50 && !txen8; i++) @(negedge clk);
            repeat (1200) @(posedge clk);
            rd(0, 3'd1, 16'h0024, "t6_txe_before_pop3");
            repeat (130) @(posedge clk);
            rd(0, 3'd1, 16'h002C, "t6_txe_after_pop3");
         end
      join
      chk("t6_timeout", 32'(to), 32'd0);
      chk("t6_txen_len", 32'(len), 32'd1920);
      chk("t6_txd_bits", 32'(bits[29:0]), 32'({10'h266, 10'h244, 10'h222}));
      wr(0, 3'd1, 16'd0);
      rx_drv8 = 1'b0;
      repeat (320) @(posedge clk);
      rd(0, 3'd0, 16'h5000, "t3_brk_word");
      rd(0, 3'd1, 16'h000C, "t3_no_second");
      repeat (160) @(posedge clk);
      rd(0, 3'd1, 16'h000C, "t3_still_low");
      rx_drv8 = 1'b1;
      repeat (40) @(posedge clk);
      rd(0, 3'd1, 16'h000C, "t3_after_high");
      send8(8'h5A);
      repeat (20) @(posedge clk);
      rd(0, 3'd0, 16'h005A, "t3_recover");
      wr(0, 3'd2, 16'h0010);
      repeat (3) @(negedge clk);
      chk("t3_brk_txd", 32'(txd8), 32'd0);
      chk("t3_brk_txen", 32'(txen8), 32'd1);
      rd(0, 3'd1, 16'h002C, "t3_brk_status");
      rd(0, 3'd2, 16'h0010, "t3_brk_ctrl");
      wr(0, 3'd2, 16'h0000);
      repeat (3) @(negedge clk);
      chk("t3_unbrk_txd", 32'(txd8), 32'd1);
      chk("t3_unbrk_txen", 32'(txen8), 32'd0);
      for (int i = 0; i < 33; i++) send8(8'h40 + 8'(i));
      repeat (20) @(posedge clk);
      rd(0, 3'd1, 16'h001F, "t4_full_ovr");
      for (int i = 0; i < 32; i++) rd(0, 3'd0, 16'h0040 + 16'(i), "t4_word");
      rd(0, 3'd1, 16'h000C, "t4_ovr_cleared");
      send8(8'h55);
      send8(8'h66);
      repeat (20) @(posedge clk);
      rd(0, 3'd1, 16'h000D, "fl_two_words");
      wr(0, 3'd2, 16'h0020);
      rd(0, 3'd1, 16'h000C, "fl_empty");
      rd(0, 3'd2, 16'h0000, "fl_ctrl");
      rx_drv8 = 1'b0;
      repeat (4) @(posedge clk);
      rx_drv8 = 1'b1;
      repeat (100) @(posedge clk);
      rd(0, 3'd1, 16'h000C, "t5_glitch");
      send8(8'h3C);
      repeat (20) @(posedge clk);
      rd(0, 3'd0, 16'h003C, "t5_after_glitch");
      loop = 1'b1;
      wr(0, 3'd2, 16'h0008);
      wr(0, 3'd0, 16'h0001);
      wr(0, 3'd0, 16'h0002);
      wr(0, 3'd0, 16'h0003);
      repeat (700) @(posedge clk);
      rd(0, 3'd1, 16'h000C, "t5_half_duplex");
      rd(0, 3'd2, 16'h0008, "t5_hd_ctrl");
      wr(0, 3'd2, 16'h0000);
      loop = 1'b0;
      wr(1, 3'd2, 16'h0005);
      rd(1, 3'd2, 16'h0005, "t2_ctrl");
      send7(7'h41, 1'b1, 1'b1);
      repeat (40) @(posedge clk);
      rd(1, 3'd0, 16'h2041, "t2_pe");
      send7(7'h41, 1'b0, 1'b0);
      repeat (40) @(posedge clk);
      rd(1, 3'd0, 16'h4041, "t2_fe");
      send7(7'h41, 1'b0, 1'b1);
      repeat (40) @(posedge clk);
      rd(1, 3'd0, 16'h0041, "t2_good");
      send7(7'h00, 1'b1, 1'b1);
      repeat (40) @(posedge clk);
      rd(1, 3'd0, 16'h2000, "t2_zero_pe");
      rd(1, 3'd1, 16'h000C, "t2_status");
      repeat (5) @(posedge clk);
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
